// File: rtl/unified_mem_ctrl.sv
// ---------------------------------------------------------------------------
// unified_mem_ctrl
//
// Puts the single-cycle CPU's instruction fetches, loads and stores onto one
// external single-port memory bus, one at a time. Each access uses a
// variable-latency req/ack handshake. Every CPU request gets exactly one done
// pulse, including accesses that are misaligned or that time out, so the CPU
// can never hang waiting on the memory.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   fetch_req, pc     fetch request (level) and address
//   read_inst         last fetched instruction
//   fetch_done        one-cycle pulse when read_inst is valid
//   load_en, l_addr   load request (level) and address
//   l_data            last load data
//   load_done         one-cycle pulse when l_data is valid
//   store_en, s_addr,
//   s_data            store request (level), address and data
//   store_done        one-cycle pulse when the store is committed
//   busy              high in every state except IDLE
//   bus_req, bus_we,
//   bus_addr,
//   bus_wdata         external bus request, direction, address, write data
//   bus_ack,
//   bus_rdata         external completion; read data is valid with the ack
//   err_misalign      sticky flag: an access had addr[1:0] != 0
//   err_timeout       sticky flag: the bus did not ack within TIMEOUT cycles
// ---------------------------------------------------------------------------
module unified_mem_ctrl #(
   parameter int W       = 32,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         fetch_req,
   input  logic [W-1:0] pc,
   output logic [W-1:0] read_inst,
   output logic         fetch_done,
   input  logic         load_en,
   input  logic [W-1:0] l_addr,
   output logic [W-1:0] l_data,
   output logic         load_done,
   input  logic         store_en,
   input  logic [W-1:0] s_addr,
   input  logic [W-1:0] s_data,
   output logic         store_done,
   output logic         busy,
   output logic         bus_req,
   output logic         bus_we,
   output logic [W-1:0] bus_addr,
   output logic [W-1:0] bus_wdata,
   input  logic         bus_ack,
   input  logic [W-1:0] bus_rdata,
   output logic         err_misalign,
   output logic         err_timeout
);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;
   typedef enum logic [1:0] {KIND_FETCH, KIND_LOAD, KIND_STORE} kind_t;

   // The counter counts cycles already spent without an ack. The access
   // aborts on the cycle the counter reaches TIMEOUT-1 with no ack. This
   // keeps bus_req high for exactly TIMEOUT cycles.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t       state;
   state_t       state_nxt;
   kind_t        kind;
   kind_t        sel_kind;
   logic [7:0]   tmo_cnt;
   logic         any_req;
   logic         misaligned;
   logic         tmo_hit;
   logic [W-1:0] sel_addr;

   // Fixed-priority arbitration among the pending requests:
   // store > load > fetch. Only the winner's address is checked for
   // alignment and latched.
   always_comb begin
      any_req  = store_en | load_en | fetch_req;
      sel_kind = KIND_FETCH;
      sel_addr = pc;
      if (store_en) begin
         sel_kind = KIND_STORE;
         sel_addr = s_addr;
      end else if (load_en) begin
         sel_kind = KIND_LOAD;
         sel_addr = l_addr;
      end
      misaligned = (sel_addr[1:0] != 2'b00);
      tmo_hit    = (tmo_cnt == TMO_LAST) && !bus_ack;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic. A misaligned request skips the bus phase and goes
   // straight to DONE. A bus phase ends on an ack or on a timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               if (misaligned)
                  state_nxt = DONE;
               else if (sel_kind == KIND_STORE)
                  state_nxt = STORE;
               else if (sel_kind == KIND_LOAD)
                  state_nxt = LOAD;
               else
                  state_nxt = FETCH;
            end
         end
         FETCH, LOAD, STORE: begin
            if (bus_ack || tmo_hit)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers. The request is captured at acceptance, so later
   // input changes cannot disturb the bus. Read data is taken on the ack
   // cycle. An access that fails (misaligned or timed out) zeroes the data
   // output for its own request type and sets the matching sticky flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         kind         <= KIND_FETCH;
         tmo_cnt      <= '0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         read_inst    <= '0;
         l_data       <= '0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (any_req) begin
                  kind <= sel_kind;
                  if (misaligned) begin
                     err_misalign <= 1'b1;
                     if (sel_kind == KIND_LOAD)
                        l_data <= '0;
                     if (sel_kind == KIND_FETCH)
                        read_inst <= '0;
                  end else begin
                     bus_addr <= sel_addr;
                     if (sel_kind == KIND_STORE)
                        bus_wdata <= s_data;
                  end
               end
            end
            FETCH, LOAD, STORE: begin
               if (bus_ack) begin
                  tmo_cnt <= '0;
                  if (state == FETCH)
                     read_inst <= bus_rdata;
                  if (state == LOAD)
                     l_data <= bus_rdata;
               end else if (tmo_hit) begin
                  tmo_cnt     <= '0;
                  err_timeout <= 1'b1;
                  if (state == FETCH)
                     read_inst <= '0;
                  if (state == LOAD)
                     l_data <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: tmo_cnt <= '0;
         endcase
      end
   end

   // Moore outputs. bus_req is high only in the bus states, so it drops as
   // DONE is entered and stays low for at least that one cycle. The done
   // pulse comes from the single DONE cycle, so at most one is ever high.
   always_comb begin
      busy       = (state != IDLE);
      bus_req    = (state == FETCH) || (state == LOAD) || (state == STORE);
      bus_we     = (state == STORE);
      fetch_done = (state == DONE) && (kind == KIND_FETCH);
      load_done  = (state == DONE) && (kind == KIND_LOAD);
      store_done = (state == DONE) && (kind == KIND_STORE);
   end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_ctrl
//
// Directed testbench for unified_mem_ctrl (TIMEOUT = 8). It contains a
// 256-word bus memory model whose ack delay can be programmed and whose ack
// can be switched off. Outputs are sampled on the falling clock edge, and
// inputs are also driven there.
// ---------------------------------------------------------------------------
module tb_unified_mem_ctrl;

   localparam int W       = 32;
   localparam int TMO     = 8;
   localparam int K_FETCH = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         fetch_req, load_en, store_en;
   logic [W-1:0] pc, l_addr, s_addr, s_data;
   logic [W-1:0] read_inst, l_data;
   logic         fetch_done, load_done, store_done, busy;
   logic         bus_req, bus_we, bus_ack;
   logic [W-1:0] bus_addr, bus_wdata, bus_rdata;
   logic         err_misalign, err_timeout;

   int checks = 0;
   int errors = 0;

   logic         ack_on = 1'b1;
   int           ack_delay = 1;
   int           wait_cnt = 0;
   logic [W-1:0] mem [0:255];

   always #5 clk = ~clk;

   unified_mem_ctrl #(.W(W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .pc(pc), .read_inst(read_inst), .fetch_done(fetch_done),
      .load_en(load_en), .l_addr(l_addr), .l_data(l_data), .load_done(load_done),
      .store_en(store_en), .s_addr(s_addr), .s_data(s_data), .store_done(store_done),
      .busy(busy), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .err_misalign(err_misalign), .err_timeout(err_timeout)
   );

   // Bus memory model. The ack arrives on the ack_delay-th cycle of a
   // request. Writes commit on the ack, and the preload is restored on reset.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[16]  <= 32'h2008_0005;
         mem[128] <= 32'h1111_2222;
         mem[192] <= 32'h3333_4444;
         wait_cnt <= 0;
      end else begin
         if (bus_req && bus_ack && bus_we) mem[bus_addr[9:2]] <= bus_wdata;
         wait_cnt <= bus_req ? wait_cnt + 1 : 0;
      end
   end

   assign bus_ack   = bus_req && ack_on && (wait_cnt == ack_delay - 1);
   assign bus_rdata = mem[bus_addr[9:2]];

   // One comparison: counts it, and reports and counts a failure.
   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Raises one request and holds it until its done pulse, within a bounded
   // number of cycles. Returns the falling edge (1-based) on which done
   // appeared, or 0 if it never appeared, plus the number of bus_req cycles.
   // Returns on the falling edge after done, when the controller is idle.
   task automatic apply_stimulus(input int kind, input logic [31:0] addr, input logic [31:0] data,
                                 input int limit, output int done_at, output int req_cycles);
      done_at    = 0;
      req_cycles = 0;
      case (kind)
         K_FETCH: begin fetch_req = 1'b1; pc = addr; end
         K_LOAD:  begin load_en = 1'b1; l_addr = addr; end
         default: begin store_en = 1'b1; s_addr = addr; s_data = data; end
      endcase
      for (int i = 1; i <= limit && done_at == 0; i++) begin
         @(negedge clk);
         if (bus_req) req_cycles++;
         if ((kind == K_FETCH && fetch_done) || (kind == K_LOAD && load_done) ||
             (kind == K_STORE && store_done)) begin
            done_at   = i;
            fetch_req = 1'b0;
            load_en   = 1'b0;
            store_en  = 1'b0;
         end
      end
      fetch_req = 1'b0;
      load_en   = 1'b0;
      store_en  = 1'b0;
      @(negedge clk);
   endtask

   int   done_at, req_cycles, held, done_cnt, n_done, n_bus, overlap, stray;
   int   done_order [3];
   logic bus_log_we [3];
   logic [W-1:0] bus_log_addr [3];
   logic prev_req;

   // Directed sequence.
   initial begin
      rst = 1'b1; fetch_req = 1'b0; load_en = 1'b0; store_en = 1'b0;
      pc = '0; l_addr = '0; s_addr = '0; s_data = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_output("rst_busy",      {31'b0, busy}, 0);
      check_output("rst_bus_req",   {31'b0, bus_req}, 0);
      check_output("rst_bus_addr",  bus_addr, 0);
      check_output("rst_read_inst", read_inst, 0);
      check_output("rst_errs",      {30'b0, err_misalign, err_timeout}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Fetch, ack in the first bus cycle
      ack_delay = 1;
      fetch_req = 1'b1; pc = 32'h0000_0040;
      @(negedge clk);
      check_output("f_bus_req",  {31'b0, bus_req}, 1);
      check_output("f_bus_we",   {31'b0, bus_we}, 0);
      check_output("f_bus_addr", bus_addr, 32'h40);
      check_output("f_early_done", {31'b0, fetch_done}, 0);
      @(negedge clk);
      check_output("f_done",      {31'b0, fetch_done}, 1);
      check_output("f_read_inst", read_inst, 32'h2008_0005);
      check_output("f_req_low",   {31'b0, bus_req}, 0);
      check_output("f_other_done", {30'b0, load_done, store_done}, 0);
      fetch_req = 1'b0;
      @(negedge clk);
      check_output("f_done_pulse", {31'b0, fetch_done}, 0);
      check_output("f_idle_busy",  {30'b0, busy, bus_req}, 0);

      // Store with ack on the 4th bus cycle; s_data changes mid-access
      ack_delay = 4;
      store_en = 1'b1; s_addr = 32'h100; s_data = 32'hDEAD_BEEF;
      held = 0; done_cnt = 0; done_at = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (bus_req && bus_we && bus_wdata == 32'hDEAD_BEEF && bus_addr == 32'h100) held++;
         if (store_done) begin
            done_cnt++;
            if (done_at == 0) done_at = i;
            store_en = 1'b0;
         end
         if (i == 1) s_data = 32'h0;
      end
      check_output("s_held",     held, 4);
      check_output("s_done_cnt", done_cnt, 1);
      check_output("s_done_at",  done_at, 5);

      // Load back the stored word
      ack_delay = 1;
      apply_stimulus(K_LOAD, 32'h100, 0, 10, done_at, req_cycles);
      check_output("l_done_at", done_at, 2);
      check_output("l_data",    l_data, 32'hDEAD_BEEF);

      // Simultaneous requests: store, then load (same word), then fetch
      ack_delay = 2;
      store_en = 1'b1; s_addr = 32'h200; s_data = 32'hCAFE_F00D;
      load_en = 1'b1; l_addr = 32'h200;
      fetch_req = 1'b1; pc = 32'h300;
      n_done = 0; n_bus = 0; overlap = 0; prev_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         done_order[k] = -1; bus_log_we[k] = 1'b0; bus_log_addr[k] = '0;
      end
      for (int i = 1; i <= 40 && n_done < 3; i++) begin
         @(negedge clk);
         if (bus_req && !prev_req && n_bus < 3) begin
            bus_log_we[n_bus] = bus_we; bus_log_addr[n_bus] = bus_addr; n_bus++;
         end
         prev_req = bus_req;
         if (int'(fetch_done) + int'(load_done) + int'(store_done) > 1) overlap++;
         if (store_done && n_done < 3) begin done_order[n_done] = K_STORE; n_done++; store_en = 1'b0; end
         if (load_done && n_done < 3)  begin done_order[n_done] = K_LOAD;  n_done++; load_en = 1'b0; end
         if (fetch_done && n_done < 3) begin done_order[n_done] = K_FETCH; n_done++; fetch_req = 1'b0; end
      end
      store_en = 1'b0; load_en = 1'b0; fetch_req = 1'b0;
      @(negedge clk);
      check_output("m_n_done",  n_done, 3);
      check_output("m_order0",  done_order[0], K_STORE);
      check_output("m_order1",  done_order[1], K_LOAD);
      check_output("m_order2",  done_order[2], K_FETCH);
      check_output("m_overlap", overlap, 0);
      check_output("m_bus0_we", {31'b0, bus_log_we[0]}, 1);
      check_output("m_bus1",    bus_log_addr[1], 32'h200);
      check_output("m_bus2",    bus_log_addr[2], 32'h300);
      check_output("m_l_data",  l_data, 32'hCAFE_F00D);
      check_output("m_inst",    read_inst, 32'h3333_4444);

      // Misaligned load, then valid accesses with the flag still set
      ack_delay = 1;
      apply_stimulus(K_LOAD, 32'h102, 0, 5, done_at, req_cycles);
      check_output("ma_done_at",  done_at, 1);
      check_output("ma_no_req",   req_cycles, 0);
      check_output("ma_l_data",   l_data, 0);
      check_output("ma_flag",     {31'b0, err_misalign}, 1);
      apply_stimulus(K_FETCH, 32'h40, 0, 5, done_at, req_cycles);
      check_output("ma_f_inst",   read_inst, 32'h2008_0005);
      apply_stimulus(K_LOAD, 32'h200, 0, 5, done_at, req_cycles);
      check_output("ma_l_data2",  l_data, 32'hCAFE_F00D);
      check_output("ma_sticky",   {30'b0, err_misalign, err_timeout}, 32'h2);

      // Bus never acks: timeout after TMO bus cycles
      ack_on = 1'b0;
      apply_stimulus(K_LOAD, 32'h200, 0, 20, done_at, req_cycles);
      check_output("to_req_cycles", req_cycles, TMO);
      check_output("to_done_at",    done_at, TMO + 1);
      check_output("to_l_data",     l_data, 0);
      check_output("to_flag",       {31'b0, err_timeout}, 1);
      ack_on = 1'b1;
      apply_stimulus(K_LOAD, 32'h100, 0, 10, done_at, req_cycles);
      check_output("to_next_done", done_at, 2);
      check_output("to_next_data", l_data, 32'hDEAD_BEEF);

      // Reset in the 2nd cycle of a pending load
      ack_delay = 5;
      load_en = 1'b1; l_addr = 32'h100;
      @(negedge clk);
      check_output("r_req_before", {31'b0, bus_req}, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      check_output("r_bus_req",   {31'b0, bus_req}, 0);
      check_output("r_busy",      {31'b0, busy}, 0);
      check_output("r_load_done", {31'b0, load_done}, 0);
      check_output("r_l_data",    l_data, 0);
      check_output("r_errs",      {30'b0, err_misalign, err_timeout}, 0);
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (load_done || bus_req) stray++;
      end
      check_output("r_no_stray", stray, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Sits directly downstream of the single-cycle CPU's memory ports.
- Serialises the CPU's instruction-fetch, load and store requests onto one external single-port memory bus with a variable-latency req/ack handshake.
- Returns the fetched instruction and load data to the CPU, raising a done pulse for each request.
- Flags misaligned accesses and bus timeouts.

Parameters:
- W, 32, data/address word width (matches `WORD_WIDTH).
- TIMEOUT, 255, maximum cycles to wait for bus_ack before aborting; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- fetch_req  in  1  instruction fetch request; level, held until fetch_done
- pc  in  W  fetch address
- read_inst  out  W  last fetched instruction
- fetch_done  out  1  one-cycle pulse; read_inst valid
- load_en  in  1  load request; level, held until load_done
- l_addr  in  W  load address
- l_data  out  W  last load data
- load_done  out  1  one-cycle pulse; l_data valid
- store_en  in  1  store request; level, held until store_done
- s_addr  in  W  store address
- s_data  in  W  store data
- store_done  out  1  one-cycle pulse; store committed
- busy  out  1  high whenever state != IDLE
- bus_req  out  1  external request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  W  word-aligned external address
- bus_wdata  out  W  write data
- bus_ack  in  1  external completion; rdata valid in same cycle
- bus_rdata  in  W  external read data
- err_misalign  out  1  sticky; set on any access with addr[1:0] != 0
- err_timeout  out  1  sticky; set on bus timeout

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; all outputs 0 (read_inst, l_data, bus_addr, bus_wdata cleared; done pulses, bus_req, bus_we, busy, both err flags 0); timeout counter 0. Reset mid-transaction abandons it: bus_req drops the cycle after reset is sampled, and no done pulse is issued.
- States: IDLE, FETCH, LOAD, STORE, DONE.
- IDLE arbitration when any request is high, fixed priority store > load > fetch:
  - The address is checked and, if aligned, the address and s_data are latched into bus_addr/bus_wdata.
  - bus_req=1 from the next cycle, with bus_we=1 only for STORE.
  - Next state is STORE, LOAD or FETCH.
- Misaligned request (addr[1:0] != 0): no bus access. err_misalign is set, the data output is set to 0, the matching done pulse fires the next cycle, then state goes to DONE.
- FETCH/LOAD/STORE: bus_req, bus_we, bus_addr and bus_wdata are held stable until bus_ack=1 is sampled. On ack:
  - FETCH: read_inst <= bus_rdata and fetch_done pulses next cycle.
  - LOAD: l_data <= bus_rdata and load_done pulses next cycle.
  - STORE: store_done pulses next cycle.
  - bus_req drops in the same cycle as the done pulse, and state moves to DONE.
- Timeout: the counter increments each cycle in FETCH/LOAD/STORE without ack. When it reaches TIMEOUT, the access aborts:
  - err_timeout is set and bus_req drops.
  - The data output is set to 0 and the done pulse fires anyway, so the CPU never hangs.
  - State moves to DONE. The counter clears on leaving these states.
- DONE: lasts exactly one cycle, then IDLE. This guarantees bus_req is low for at least one cycle between transactions and gives the CPU one cycle to drop the request, so it is not re-accepted.
- Latency: with ack in the first bus cycle, done is seen 3 cycles after the request is sampled in IDLE (IDLE accept, bus cycle, done).
- Simultaneous requests are served one per transaction, in priority order; lower-priority requests wait in IDLE.
- Each request's inputs are sampled only at acceptance. Changes during the transaction are ignored.
- read_inst and l_data hold their values until the next completion of the same type.
- err flags clear only on reset.
- At most one done signal is high in any cycle. busy=0 only in IDLE.

Test Plan:
- Fetch, ack on first bus cycle: fetch_req=1, pc=0x0000_0040, bus_rdata=0x2008_0005 → bus_req=1, bus_we=0, bus_addr=0x40; fetch_done pulses 1 cycle with read_inst=0x2008_0005; bus_req low for ≥1 cycle after.
- Store with 4-cycle ack delay: store_en=1, s_addr=0x100, s_data=0xDEAD_BEEF → bus_we=1 and bus_wdata held 4 cycles; store_done pulses once; a following load of 0x100 returns 0xDEAD_BEEF from the bus model in l_data.
- Simultaneous store_en, load_en and fetch_req → bus order is STORE, LOAD, FETCH; three done pulses in that order, never overlapping.
- Misaligned load l_addr=0x102 → no bus_req; load_done pulses with l_data=0; err_misalign=1 stays set through later valid accesses.
- Bus never acks, TIMEOUT=8 → bus_req high exactly 8 cycles, then load_done with l_data=0 and err_timeout=1; the next request proceeds normally.
- rst asserted mid-LOAD (cycle 2 of pending ack) → next cycle: bus_req=0, busy=0, no load_done, l_data=0, err flags 0.
